timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Shares one millisecond-resolution countdown timer among `num_req` requesters using round-robin arbitration. A requester raises `req` with a duration, receives a held one-hot `grant` while it owns the timer, and gets a one-cycle `done` pulse when its duration expires. The block sits between protocol/control FSMs that need timeouts and the single shared timing resource, so those FSMs do not each instantiate a private counter.

## Interface
- `num_req`, 4: number of requesters, ≥2.
- `dur_width`, 10: width of each duration field, in ms ticks.
- `tick_cycles`, 50000: clk cycles per tick (1 ms at 50 MHz), ≥1.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  num_req  per-requester request level; held until `done` or abandon.
- `dur_ms`  in  num_req*dur_width  flat durations; requester i uses bits [i*dur_width +: dur_width].
- `cancel`  in  num_req  per-requester abort.
- `grant`  out  num_req  one-hot owner indication; all zero when no owner.
- `done`  out  num_req  one-cycle expiry pulse to the owner.
- `busy`  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, `grant`=0, `done`=0, `busy`=0, remaining=0, prescaler=0. RR pointer = num_req-1, so requester 0 has top priority first.
- Eligible set = `req & ~cancel`.
- IDLE:
  - If eligible is non-zero, pick the first eligible index after the pointer, wrapping.
  - Latch owner, remaining = owner's `dur_ms`, prescaler = 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN: `grant[owner]`=1.
  - Abort: if `cancel[owner]`=1 or `req[owner]`=0, go to IDLE, pointer = owner, no `done`.
  - Else if remaining==0, go to DONE.
  - Else the prescaler increments. When prescaler==tick_cycles-1, the prescaler returns to 0 and remaining decrements.
- DONE: `done[owner]`=1 for exactly one cycle, `grant`=0, pointer = owner, then go to IDLE.
- Durations are latched at grant. `dur_ms` changes during RUN are ignored.
- `cancel` and `req` changes from non-owners are ignored outside IDLE.
- A requester whose `req` is still high after DONE is re-eligible, but has the lowest priority.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Arithmetic:
  - remaining is dur_width bits and never decrements below 0.
  - The prescaler is $clog2(tick_cycles) bits, minimum 1.

## Timing
- The arbitration cycle is the cycle in which IDLE samples an eligible request; call it cycle 0.
- Grant:
  - `grant` rises in cycle 1.
  - `grant` stays high through cycle D*tick_cycles+1.
  - `grant` falls in cycle D*tick_cycles+2, where D is the latched duration.
- Done:
  - `done` pulses in cycle D*tick_cycles+2.
  - D=0 gives one grant cycle (cycle 1) and `done` in cycle 2.
- Back-to-back: IDLE follows DONE, so the next arbitration is at D*tick_cycles+3 and the next grant at D*tick_cycles+4.
- Abort: if the abort condition is seen in RUN cycle c, `grant` is low in c+1 (IDLE). Another waiting requester is granted in c+2.
- Reset mid-operation: in the cycle after `rst` is sampled, all outputs are 0. No `done` is produced for the interrupted owner.
- Simultaneous `req` and `cancel` in IDLE: that requester is not eligible.

## Structure
- Package `timer_scheduler_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - a function returning the prescaler width for a given tick_cycles.
- Sub-module `rr_arbiter`:
  - Combinational.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot pick, its index, and a valid flag.
- The top module owns the pointer register, FSM, prescaler, remaining counter and output registers.

## Test plan
All scenarios use num_req=4 and tick_cycles=4. In each, `req` is dropped in the `done` cycle unless stated.
- Single request: `req[1]`, dur=3, at cycle 0 → `grant`=0010 in cycles 1–13; `done`=0010 in cycle 14 only; `busy` high in cycles 1–14.
- Zero duration: `req[2]`, dur=0 → `grant[2]` in cycle 1 only; `done[2]` in cycle 2.
- Fairness: all four `req` high from reset release, dur=1 each → grants in order 0,1,2,3. Each `done` is 6 cycles after its arbitration cycle, and each next grant is 2 cycles after the previous `done`.
- Cancel: `req[2]` owns the timer with dur=5 and `req[3]` is waiting; `cancel[2]` is asserted at RUN cycle 7 → `grant[2]` low in cycle 8, no `done[2]`, `grant[3]` in cycle 9.
- Mid-run changes: `dur_ms[0]` changes from 2 to 9 during RUN → `done[0]` still occurs 10 cycles after arbitration. A non-owner pulsing `cancel` has no effect.
- Reset mid-RUN: `rst` pulsed while requester 3 owns the timer, all `req` high → all outputs 0 the next cycle; first grant after release goes to requester 0.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for the round-robin timer scheduler.
package timer_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Prescaler width; a single-cycle tick still needs one bit of storage.
  function automatic int presc_width(input int tick_cycles);
    return (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_arbiter #(
  parameter int num_req = 4,
  parameter int idx_w   = $clog2(num_req)
) (
  input  logic [num_req-1:0] eligible,
  input  logic [idx_w-1:0]   ptr,
  output logic [num_req-1:0] pick,
  output logic [idx_w-1:0]   idx,
  output logic               valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= num_req; k++) begin
      if (!valid && eligible[idx_w'((int'(ptr) + k) % num_req)]) begin
        valid     = 1'b1;
        idx       = idx_w'((int'(ptr) + k) % num_req);
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// One shared ms countdown timer, handed out round-robin to num_req requesters.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int num_req     = 4,
  parameter int dur_width   = 10,
  parameter int tick_cycles = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_req-1:0]           req,
  input  logic [num_req*dur_width-1:0] dur_ms,
  input  logic [num_req-1:0]           cancel,
  output logic [num_req-1:0]           grant,
  output logic [num_req-1:0]           done,
  output logic                         busy
);

  localparam int idx_w   = $clog2(num_req);
  localparam int presc_w = presc_width(tick_cycles);
  localparam logic [presc_w-1:0] presc_last = presc_w'(tick_cycles - 1);

  state_t                 state, state_nxt;
  logic [idx_w-1:0]       owner, owner_nxt;
  logic [idx_w-1:0]       ptr, ptr_nxt;
  logic [dur_width-1:0]   remaining, remaining_nxt;
  logic [presc_w-1:0]     presc, presc_nxt;
  logic [num_req-1:0]     grant_nxt, done_nxt;
  logic                   busy_nxt;

  logic [num_req-1:0]     arb_pick;
  logic [idx_w-1:0]       arb_idx;
  logic                   arb_valid;
  logic [dur_width-1:0]   dur_arr [num_req];

  for (genvar g = 0; g < num_req; g++) begin : g_dur
    assign dur_arr[g] = dur_ms[g*dur_width +: dur_width];
  end

  rr_arbiter #(
    .num_req (num_req),
    .idx_w   (idx_w)
  ) u_arb (
    .eligible (req & ~cancel),
    .ptr      (ptr),
    .pick     (arb_pick),
    .idx      (arb_idx),
    .valid    (arb_valid)
  );

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    presc_nxt     = presc;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          owner_nxt     = arb_idx;
          remaining_nxt = dur_arr[arb_idx];
          presc_nxt     = '0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        // Abandon by the owner frees the timer without a done pulse.
        if (cancel[owner] || !req[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = owner;
        end else if (remaining == '0) begin
          state_nxt = DONE;
        end else if (presc == presc_last) begin
          presc_nxt     = '0;
          remaining_nxt = remaining - 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = owner;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    grant_nxt = '0;
    if (state_nxt == RUN) grant_nxt = (state == IDLE) ? arb_pick : grant;
    done_nxt = (state == RUN && state_nxt == DONE) ? grant : '0;
    busy_nxt = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= idx_w'(num_req - 1);
      remaining <= '0;
      presc     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
      presc     <= presc_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench: scenarios queue expected output changes, a monitor checks them.
module tb_timer_scheduler;

  localparam int n  = 4;
  localparam int dw = 10;
  localparam int tc = 4;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic [n-1:0]  req    = '0;
  logic [n-1:0]  cancel = '0;
  logic [n*dw-1:0] dur_ms = '0;
  logic [n-1:0]  grant, done;
  logic          busy;

  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  logic [8:0] prev  = '0;

  typedef struct {
    int         cyc;
    logic [8:0] val;
  } ev_t;
  ev_t exp_q[$];

  timer_scheduler #(
    .num_req     (n),
    .dur_width   (dw),
    .tick_cycles (tc)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .dur_ms (dur_ms),
    .cancel (cancel),
    .grant  (grant),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected output tuple {grant, done, busy} from cycle c onward.
  task automatic expect_ev(input int c, input logic [3:0] g, input logic [3:0] d, input logic b);
    ev_t e;
    e.cyc = c;
    e.val = {g, d, b};
    exp_q.push_back(e);
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_dur(input int i, input int v);
    dur_ms[i*dw +: dw] = dw'(v);
  endtask

  // Monitor: every change of the output tuple must match the next queued event.
  always @(negedge clk) begin
    logic [8:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {grant, done, busy};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected change @%0d: got %0h, expected no change from %0h", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("event@%0d cycle", e.cyc), cyc, e.cyc);
          check($sformatf("event@%0d outputs", e.cyc), {23'd0, cur}, {23'd0, e.val});
        end
        prev = cur;
      end
    end
  end

  initial begin
    int  t0;
    ev_t e;

    goto(3);
    check("reset outputs", {23'd0, grant, done, busy}, 32'd0);
    rst    = 1'b0;
    prev   = '0;
    mon_en = 1'b1;

    // Single request: requester 1, dur 3.
    t0 = 5;
    goto(t0);
    expect_ev(t0 + 1,  4'b0010, 4'b0000, 1'b1);
    expect_ev(t0 + 14, 4'b0000, 4'b0010, 1'b1);
    expect_ev(t0 + 15, 4'b0000, 4'b0000, 1'b0);
    set_dur(1, 3);
    req = 4'b0010;
    goto(t0 + 14);
    req = '0;
    goto(t0 + 16);

    // Zero duration: requester 2.
    t0 = cyc;
    expect_ev(t0 + 1, 4'b0100, 4'b0000, 1'b1);
    expect_ev(t0 + 2, 4'b0000, 4'b0100, 1'b1);
    expect_ev(t0 + 3, 4'b0000, 4'b0000, 1'b0);
    set_dur(2, 0);
    req = 4'b0100;
    goto(t0 + 2);
    req = '0;
    goto(t0 + 4);

    // Fairness: all four requesting from reset release, dur 1 each.
    t0 = cyc;
    rst = 1'b1;
    goto(t0 + 2);
    rst = 1'b0;
    for (int i = 0; i < n; i++) set_dur(i, 1);
    req = 4'b1111;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      expect_ev(t0 + 7*i + 1, 4'(1 << i), 4'b0000, 1'b1);
      expect_ev(t0 + 7*i + 6, 4'b0000, 4'(1 << i), 1'b1);
      expect_ev(t0 + 7*i + 7, 4'b0000, 4'b0000, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      goto(t0 + 7*i + 6);
      req[i] = 1'b0;
    end
    goto(t0 + 29);

    // Cancel: requester 2 owns (dur 5), 3 waits; cancel[2] in RUN cycle 7.
    t0 = cyc;
    expect_ev(t0 + 1,  4'b0100, 4'b0000, 1'b1);
    expect_ev(t0 + 8,  4'b0000, 4'b0000, 1'b0);
    expect_ev(t0 + 9,  4'b1000, 4'b0000, 1'b1);
    expect_ev(t0 + 14, 4'b0000, 4'b1000, 1'b1);
    expect_ev(t0 + 15, 4'b0000, 4'b0000, 1'b0);
    set_dur(2, 5);
    set_dur(3, 1);
    req = 4'b1100;
    goto(t0 + 7);
    cancel = 4'b0100;
    goto(t0 + 8);
    req    = 4'b1000;
    cancel = '0;
    goto(t0 + 14);
    req = '0;
    goto(t0 + 16);

    // Mid-run dur change and non-owner cancel are ignored.
    t0 = cyc;
    expect_ev(t0 + 1,  4'b0001, 4'b0000, 1'b1);
    expect_ev(t0 + 10, 4'b0000, 4'b0001, 1'b1);
    expect_ev(t0 + 11, 4'b0000, 4'b0000, 1'b0);
    set_dur(0, 2);
    req = 4'b0001;
    goto(t0 + 3);
    set_dur(0, 9);
    goto(t0 + 4);
    cancel = 4'b1110;
    goto(t0 + 5);
    cancel = '0;
    goto(t0 + 10);
    req = '0;
    goto(t0 + 12);

    // Reset while requester 3 owns, all requesting; pointer restarts at 0.
    t0 = cyc;
    expect_ev(t0 + 1, 4'b1000, 4'b0000, 1'b1);
    expect_ev(t0 + 5, 4'b0000, 4'b0000, 1'b0);
    expect_ev(t0 + 7, 4'b0001, 4'b0000, 1'b1);
    expect_ev(t0 + 8, 4'b0000, 4'b0001, 1'b1);
    expect_ev(t0 + 9, 4'b0000, 4'b0000, 1'b0);
    set_dur(3, 5);
    set_dur(0, 0);
    req = 4'b1000;
    goto(t0 + 2);
    req = 4'b1111;
    goto(t0 + 4);
    rst = 1'b1;
    goto(t0 + 6);
    rst = 1'b0;
    goto(t0 + 8);
    req = '0;
    goto(t0 + 12);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing event@%0d: got no change, expected %0h", e.cyc, e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
